// File: rtl/second_highest_pkg.sv
// Shared defaults for the self-stimulating second-highest tracker.
package second_highest_pkg;

  localparam int          DEFAULT_N    = 32;
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

endpackage

// File: rtl/lfsr_gen.sv
// Right-shifting Galois LFSR, one step per clock, with a lock-up guard
// that reloads the seed if the register ever reads zero.
module lfsr_gen
  import second_highest_pkg::*;
#(
  parameter int         N    = DEFAULT_N,
  parameter logic [N-1:0] TAPS = N'(DEFAULT_TAPS),
  parameter logic [N-1:0] SEED = N'(DEFAULT_SEED)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] value_out
);

  // A zero seed would lock the register at zero forever.
  localparam logic [N-1:0] SEED_EFF = (SEED == '0) ? N'(1) : SEED;

  logic [N-1:0] lfsr_q;
  logic [N-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q == '0) begin
      lfsr_d = SEED_EFF;
    end else if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ TAPS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_out = lfsr_q;

endmodule

// File: rtl/second_highest_dut.sv
// Tracks the largest and second-largest distinct samples produced by an
// internal LFSR since reset. Outputs come straight from registers.
module second_highest_dut
  import second_highest_pkg::*;
#(
  parameter int           N    = DEFAULT_N,
  parameter logic [N-1:0] TAPS = N'(DEFAULT_TAPS),
  parameter logic [N-1:0] SEED = N'(DEFAULT_SEED)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] highest_out,
  output logic [N-1:0] second_highest_out
);

  logic [N-1:0] sample;
  logic [N-1:0] highest_q, highest_d;
  logic [N-1:0] second_q, second_d;

  lfsr_gen #(
    .N    (N),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .value_out (sample)
  );

  // Equal values fall through untouched, so a repeat never fills second.
  always_comb begin
    highest_d = highest_q;
    second_d  = second_q;
    if (sample > highest_q) begin
      second_d  = highest_q;
      highest_d = sample;
    end else if ((sample < highest_q) && (sample > second_q)) begin
      second_d = sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      highest_q <= '0;
      second_q  <= '0;
    end else begin
      highest_q <= highest_d;
      second_q  <= second_d;
    end
  end

  assign highest_out        = highest_q;
  assign second_highest_out = second_q;

endmodule

// File: tb/tb_second_highest_dut.sv
// Bench for second_highest_dut: a 32-bit default instance and a 4-bit
// instance that wraps its 15-state period, both checked against a history model.
module tb_second_highest_dut;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] hi32, se32;
  logic [3:0]  hi4, se4;

  int total = 0;
  int passed = 0;

  logic [31:0] m_lfsr32, m_lfsr4, last_sample32, last_sample4;
  logic [31:0] hist32[$];
  logic [31:0] hist4[$];
  logic [31:0] prev_hi, prev_se;

  logic [31:0] exp_hi[4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'hC030_0002};
  logic [31:0] exp_se[4] = '{32'h0000_0000, 32'h0000_0001, 32'h8020_0003, 32'h8020_0003};

  always #5 clk = ~clk;

  second_highest_dut u_dut (
    .clk                (clk),
    .reset              (reset),
    .highest_out        (hi32),
    .second_highest_out (se32)
  );

  second_highest_dut #(
    .N    (4),
    .TAPS (4'h9),
    .SEED (4'h1)
  ) u_dut4 (
    .clk                (clk),
    .reset              (reset),
    .highest_out        (hi4),
    .second_highest_out (se4)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] v, input logic [31:0] taps);
    if (v == 32'd0) return 32'd1;
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

  // Largest value in the history, then largest value strictly below it.
  function automatic void top_two(input logic [31:0] h[$], output logic [31:0] hi,
                                  output logic [31:0] sec);
    hi  = 32'd0;
    sec = 32'd0;
    foreach (h[i]) if (h[i] > hi) hi = h[i];
    foreach (h[i]) if ((h[i] < hi) && (h[i] > sec)) sec = h[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr32 = 32'd1;
    m_lfsr4  = 32'd1;
    hist32.delete();
    hist4.delete();
    prev_hi = 32'd0;
    prev_se = 32'd0;
  endtask

  task automatic do_cycle();
    logic [31:0] mh, ms;
    @(posedge clk);
    last_sample32 = m_lfsr32;
    last_sample4  = m_lfsr4;
    hist32.push_back(m_lfsr32);
    hist4.push_back(m_lfsr4);
    m_lfsr32 = lfsr_next(m_lfsr32, 32'h8020_0003);
    m_lfsr4  = lfsr_next(m_lfsr4, 32'h0000_0009);
    @(negedge clk);
    top_two(hist32, mh, ms);
    check("hi32_model", hi32, mh);
    check("se32_model", se32, ms);
    top_two(hist4, mh, ms);
    check("hi4_model", 32'(hi4), mh);
    check("se4_model", 32'(se4), ms);
    check("inv_mono", 32'(hi32 >= prev_hi), 32'd1);
    check("inv_order", 32'(hi32 >= se32), 32'd1);
    check("inv_strict", 32'((se32 == 0) || (hi32 > se32)), 32'd1);
    check("inv_strict4", 32'((se4 == 0) || (hi4 > se4)), 32'd1);
    if ((last_sample32 <= prev_se) || (last_sample32 == prev_hi)) begin
      check("mon_hold_hi", hi32, prev_hi);
      check("mon_hold_se", se32, prev_se);
    end
    if ((hi32 !== prev_hi) || (se32 !== prev_se))
      $display("%0t change highest=%h second=%h", $time, hi32, se32);
    prev_hi = hi32;
    prev_se = se32;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_hi", hi32, 32'd0);
      check("rst_se", se32, 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check($sformatf("edge%0d_hi", i + 1), hi32, exp_hi[i]);
      check($sformatf("edge%0d_se", i + 1), se32, exp_se[i]);
    end
    repeat (46) do_cycle();

    // Assert reset between edges; outputs must clear with no clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_hi", hi32, 32'd0);
    check("async_se", se32, 32'd0);
    check("async_hi4", 32'(hi4), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_cycle();
      check($sformatf("re_edge%0d_hi", i + 1), hi32, exp_hi[i]);
      check($sformatf("re_edge%0d_se", i + 1), se32, exp_se[i]);
    end

    repeat (1000) do_cycle();

    check("n4_final_hi", 32'(hi4), 32'h0000_000F);
    check("n4_final_se", 32'(se4), 32'h0000_000E);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
